// File: rtl/fib_seq_ctrl.sv
// Sequencing controller for a self-timed dual-rail Fibonacci ring: resets and arms the
// ring, collects cmd_count terms via a four-phase handshake and presents them on a valid/ready port.
module fib_seq_ctrl #(
    parameter int WIDTH      = 32,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [15:0]        cmd_count,
    output logic               fib_rst,
    output logic               fib_start,
    output logic               fib_ack,
    input  logic [2*WIDTH-1:0] fib_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic [15:0]        res_idx,
    output logic               res_wrap,
    output logic               busy,
    output logic [1:0]         err
);
    typedef enum logic [2:0] {
        IDLE, RING_RST, ARM, WAIT_DATA, PRESENT, WAIT_NULL, ERROR
    } state_t;

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1) + 1;

    state_t             state_q;
    logic [2*WIDTH-1:0] sync1_q, sync2_q, samp_q;
    logic [15:0]        count_q, idx_q;
    logic [WIDTH-1:0]   prev_q;
    logic [RCW-1:0]     rcnt_q;
    logic [TW-1:0]      tmo_q;

    logic [WIDTH-1:0]   word;
    logic               all_onehot, any_ill, is_data, is_null;
    logic               waiting, progress, fault;
    logic [1:0]         fault_code;

    // Decode the synchronized word; samp_q is the previous synchronized sample.
    always_comb begin
        word       = '0;
        all_onehot = 1'b1;
        any_ill    = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            word[i] = sync2_q[2*i+1];
            if (sync2_q[2*i] == sync2_q[2*i+1]) all_onehot = 1'b0;
            if (sync2_q[2*i] && sync2_q[2*i+1]) any_ill = 1'b1;
        end
    end

    assign is_data = all_onehot && (sync2_q == samp_q);
    assign is_null = (sync2_q == '0) && (samp_q == '0);

    always_comb begin
        waiting    = (state_q == ARM) || (state_q == WAIT_DATA) || (state_q == WAIT_NULL);
        progress   = 1'b0;
        fault      = 1'b0;
        fault_code = 2'd0;
        case (state_q)
            ARM:       progress = is_null;
            WAIT_DATA: progress = is_data;
            WAIT_NULL: progress = is_null;
            default:   progress = 1'b0;
        endcase
        // Illegal code takes precedence over a simultaneous timeout.
        if (((state_q == WAIT_DATA) || (state_q == WAIT_NULL)) && any_ill) begin
            fault      = 1'b1;
            fault_code = 2'd2;
        end else if (waiting && !progress && (tmo_q == TW'(TIMEOUT))) begin
            fault      = 1'b1;
            fault_code = 2'd1;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            samp_q    <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            prev_q    <= '0;
            rcnt_q    <= '0;
            tmo_q     <= '0;
            fib_rst   <= 1'b1;
            fib_start <= 1'b0;
            fib_ack   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            res_wrap  <= 1'b0;
            err       <= 2'd0;
        end else begin
            sync1_q <= fib_out;
            sync2_q <= sync1_q;
            samp_q  <= sync2_q;

            if (waiting) begin
                tmo_q <= progress ? '0 : tmo_q + 1'b1;
            end

            if (fault) begin
                state_q   <= ERROR;
                err       <= fault_code;
                fib_rst   <= 1'b1;
                fib_start <= 1'b0;
                fib_ack   <= 1'b0;
                res_valid <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cmd_valid && (cmd_count != 16'd0)) begin
                            count_q <= cmd_count;
                            idx_q   <= '0;
                            rcnt_q  <= '0;
                            fib_rst <= 1'b1;
                            state_q <= RING_RST;
                        end
                    end
                    RING_RST: begin
                        if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
                            fib_rst <= 1'b0;
                            tmo_q   <= '0;
                            state_q <= ARM;
                        end else begin
                            rcnt_q <= rcnt_q + 1'b1;
                        end
                    end
                    ARM: begin
                        if (is_null) begin
                            fib_start <= 1'b1;
                            state_q   <= WAIT_DATA;
                        end
                    end
                    WAIT_DATA: begin
                        if (is_data) begin
                            res_data  <= word;
                            res_idx   <= idx_q;
                            res_wrap  <= (idx_q != 16'd0) && (word < prev_q);
                            res_valid <= 1'b1;
                            state_q   <= PRESENT;
                        end
                    end
                    PRESENT: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            prev_q    <= res_data;
                            fib_ack   <= 1'b1;
                            state_q   <= WAIT_NULL;
                        end
                    end
                    WAIT_NULL: begin
                        if (is_null) begin
                            fib_ack <= 1'b0;
                            idx_q   <= idx_q + 16'd1;
                            if ((idx_q + 16'd1) == count_q) begin
                                fib_start <= 1'b0;
                                fib_rst   <= 1'b1;
                                state_q   <= IDLE;
                            end else begin
                                state_q <= WAIT_DATA;
                            end
                        end
                    end
                    default: begin
                        fib_rst   <= 1'b1;
                        fib_start <= 1'b0;
                        fib_ack   <= 1'b0;
                        res_valid <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Bench for fib_seq_ctrl: behavioral dual-rail Fibonacci ring, queue scoreboard of expected
// terms, back-pressure consumer, timeout, illegal-code and mid-run reset scenarios.
module tb_fib_seq_ctrl;
    localparam int W    = 8;
    localparam int RSTC = 4;
    localparam int TMO  = 100;

    logic           clk;
    logic           rst_n;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [15:0]    cmd_count;
    logic           fib_rst;
    logic           fib_start;
    logic           fib_ack;
    logic [2*W-1:0] fib_out;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_data;
    logic [15:0]    res_idx;
    logic           res_wrap;
    logic           busy;
    logic [1:0]     err;

    fib_seq_ctrl #(.WIDTH(W), .RST_CYCLES(RSTC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_count(cmd_count),
        .fib_rst(fib_rst), .fib_start(fib_start), .fib_ack(fib_ack), .fib_out(fib_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_idx(res_idx), .res_wrap(res_wrap), .busy(busy), .err(err)
    );

    typedef struct {
        logic [W-1:0] d;
        logic [15:0]  i;
        logic         w;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Bench controls for the ring model and the consumer
    logic ring_stall, inject_en, inj_seen;
    int   inject_k;
    logic hold_ready, stall_req, stall_done;
    int   stall_idx;
    int   stall_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
        logic [2*W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[2*i+1] = v[i];
            r[2*i]   = ~v[i];
        end
        return r;
    endfunction

    // Behavioral four-phase ring: NULL -> DATA(term) -> wait ack -> NULL -> wait !ack
    initial begin
        int ra, rb, rt, rk;
        logic rphase;
        fib_out  = '0;
        inj_seen = 1'b0;
        ra = 1; rb = 1; rk = 0; rphase = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (fib_rst) begin
                fib_out = '0; ra = 1; rb = 1; rk = 0; rphase = 1'b0;
            end else if (fib_start) begin
                if (!rphase && !fib_ack && !ring_stall) begin
                    fib_out = enc(ra[W-1:0]);
                    if (inject_en && rk == inject_k) begin
                        fib_out[7:6] = 2'b11;
                        inj_seen = 1'b1;
                    end
                    rphase = 1'b1;
                end else if (rphase && fib_ack) begin
                    fib_out = '0;
                    rt = ra + rb; ra = rb; rb = rt; rk++;
                    rphase = 1'b0;
                end
            end
        end
    end

    // Consumer: normally ready; optionally withholds ready for 50 cycles on one term
    initial begin
        logic [W-1:0] d0;
        res_ready  = 1'b1;
        stall_done = 1'b0;
        stall_bad  = 0;
        forever begin
            @(posedge clk); #2;
            if (stall_req && !stall_done && res_valid && res_idx == stall_idx[15:0]) begin
                res_ready = 1'b0;
                d0 = res_data;
                repeat (50) begin
                    @(posedge clk); #2;
                    if (fib_ack || !res_valid || res_data != d0 || res_idx != stall_idx[15:0])
                        stall_bad++;
                end
                stall_done = 1'b1;
            end
            res_ready = !hold_ready;
        end
    end

    // Scoreboard monitor: every accepted term is popped and compared
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("sb_extra_term", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                chk("res_data", 32'(res_data), 32'(mon_e.d));
                chk("res_idx", 32'(res_idx), 32'(mon_e.i));
                chk("res_wrap", 32'(res_wrap), 32'(mon_e.w));
            end
        end
    end

    task automatic push_terms(input int n);
        int a, b, t;
        logic [W-1:0] cur, prev;
        exp_t e;
        a = 1; b = 1; prev = '0;
        for (int i = 0; i < n; i++) begin
            cur = a[W-1:0];
            e.d = cur;
            e.i = 16'(i);
            e.w = (i > 0) && (cur < prev);
            sb.push_back(e);
            prev = cur;
            t = a + b; a = b; b = t;
        end
    endtask

    task automatic issue(input int n);
        @(negedge clk);
        cmd_count = 16'(n);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c;
        c = 0;
        while (busy && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n, c;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_count = '0;
        hold_ready = 1'b0; stall_req = 1'b0; stall_idx = 2;
        ring_stall = 1'b0; inject_en = 1'b0; inject_k = 0;

        repeat (3) @(negedge clk);
        chk("rst_fib_rst", 32'(fib_rst), 32'd1);
        chk("rst_fib_start", 32'(fib_start), 32'd0);
        chk("rst_fib_ack", 32'(fib_ack), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_fib_rst", 32'(fib_rst), 32'd1);

        // cmd_count = 0 is accepted but starts nothing
        issue(0);
        repeat (3) @(negedge clk);
        chk("zero_cnt_busy", 32'(busy), 32'd0);

        // Five terms, back-pressure on term 2, stray command mid-run
        stall_req = 1'b1;
        push_terms(5);
        issue(5);
        n = 0;
        while (fib_rst && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ring_rst_cycles", 32'(n), 32'(RSTC));
        cmd_count = 16'd3;
        cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle("run5_idle", 2000);
        chk("run5_sb_left", 32'(sb.size()), 32'd0);
        chk("stall_seen", 32'(stall_done), 32'd1);
        chk("stall_hold_bad", 32'(stall_bad), 32'd0);
        chk("run5_fib_start", 32'(fib_start), 32'd0);
        repeat (5) @(negedge clk);
        chk("stray_cmd_ignored", 32'(busy), 32'd0);
        chk("run5_err", 32'(err), 32'd0);

        // Fourteen terms: term 13 wraps to 121
        push_terms(14);
        issue(14);
        wait_idle("run14_idle", 3000);
        chk("run14_sb_left", 32'(sb.size()), 32'd0);
        chk("run14_last_data", 32'(res_data), 32'd121);
        chk("run14_last_wrap", 32'(res_wrap), 32'd1);

        // Timeout: ring never produces DATA
        ring_stall = 1'b1;
        issue(3);
        c = 0;
        while (!fib_start && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("tmo_start_seen", 32'(fib_start), 32'd1);
        n = 0;
        while (err == 2'd0 && n < TMO + 20) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'(TMO + 1));
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_fib_rst", 32'(fib_rst), 32'd1);
        chk("tmo_fib_start", 32'(fib_start), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd1);
        cmd_count = 16'd2;
        cmd_valid = 1'b1;
        repeat (5) @(negedge clk);
        cmd_valid = 1'b0;
        chk("tmo_sticky", 32'(err), 32'd1);
        pulse_reset();
        chk("tmo_cleared", 32'(err), 32'd0);
        ring_stall = 1'b0;

        // Illegal code on bit 3 of the second term
        inject_en = 1'b1;
        inject_k  = 1;
        push_terms(1);
        issue(3);
        c = 0;
        while (!inj_seen && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("ill_injected", 32'(inj_seen), 32'd1);
        n = 0;
        while (err == 2'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ill_latency_le3", 32'(n <= 3), 32'd1);
        chk("ill_err", 32'(err), 32'd2);
        chk("ill_res_valid", 32'(res_valid), 32'd0);
        chk("ill_sb_left", 32'(sb.size()), 32'd0);
        pulse_reset();
        inject_en = 1'b0;

        // Reset while a term is being presented
        hold_ready = 1'b1;
        repeat (2) @(negedge clk);
        issue(5);
        c = 0;
        while (!res_valid && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("pres_valid", 32'(res_valid), 32'd1);
        chk("pres_data", 32'(res_data), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_res_valid", 32'(res_valid), 32'd0);
        chk("async_res_data", 32'(res_data), 32'd0);
        chk("async_fib_rst", 32'(fib_rst), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_fib_start", 32'(fib_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hold_ready = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid) n++;
        end
        chk("post_rst_no_valid", 32'(n), 32'd0);
        push_terms(1);
        issue(1);
        wait_idle("rerun_idle", 500);
        chk("rerun_sb_left", 32'(sb.size()), 32'd0);
        chk("rerun_idx", 32'(res_idx), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fib_seq_ctrl.md
FIB_SEQ_CTRL -- requirements
Module: fib_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, data width of the dual-rail Fibonacci ring output.
REQ-002 Parameter RST_CYCLES, default 4, clock cycles fib_rst is held per run.
REQ-003 Parameter TIMEOUT, default 1024, max cycles waiting for any single handshake phase.
REQ-004 Port clk, input, 1, sole clock; all flops on rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port cmd_valid, input, 1, run request.
REQ-007 Port cmd_ready, output, 1, high only in IDLE.
REQ-008 Port cmd_count, input, 16, number of terms to collect; sampled on cmd_valid&&cmd_ready.
REQ-009 Port fib_rst, output, 1, active-high reset to the asynchronous ring.
REQ-010 Port fib_start, output, 1, barrier release to the ring.
REQ-011 Port fib_ack, output, 1, four-phase acknowledge to the ring output channel.
REQ-012 Port fib_out, input, 2*WIDTH, dual-rail data; bit i rail0 at [2i] means 0, rail1 at [2i+1] means 1.
REQ-013 Port res_valid, output, 1, result term available.
REQ-014 Port res_ready, input, 1, consumer accepts term.
REQ-015 Port res_data, output, WIDTH, decoded term.
REQ-016 Port res_idx, output, 16, zero-based index of res_data within the run.
REQ-017 Port res_wrap, output, 1, term is numerically less than the previous term (modulo wrap).
REQ-018 Port busy, output, 1, high in any state except IDLE.
REQ-019 Port err, output, 2, sticky error code: 0 none, 1 timeout, 2 illegal code (both rails of a bit high).

Function
REQ-020 fib_out SHALL pass through a 2-flop synchronizer per rail before any decode.
REQ-021 Word is DATA when every bit has exactly one rail high in two consecutive synchronized samples with identical value; NULL when all rails low in two consecutive samples.
REQ-022 FSM states: IDLE, RING_RST, ARM, WAIT_DATA, PRESENT, WAIT_NULL, ERROR.
REQ-023 IDLE: on accepted command with cmd_count=0, remain IDLE; with cmd_count>0, go to RING_RST.
REQ-024 RING_RST: fib_rst=1, fib_start=0, fib_ack=0 for exactly RST_CYCLES cycles, then ARM.
REQ-025 ARM: fib_rst=0, wait for NULL, then assert fib_start and go to WAIT_DATA; fib_start stays 1 until return to IDLE.
REQ-026 WAIT_DATA: on DATA, capture decoded word into res_data, set res_valid=1, go to PRESENT; fib_ack stays 0.
REQ-027 PRESENT: hold res_data/res_idx/res_wrap stable; on res_valid&&res_ready drop res_valid, set fib_ack=1, go to WAIT_NULL.
REQ-028 WAIT_NULL: on NULL set fib_ack=0; increment term counter; if counter equals cmd_count go to IDLE (fib_start=0), else WAIT_DATA.
REQ-029 Back-pressure from res_ready SHALL stall the ring only through withheld fib_ack; no term dropped or duplicated.
REQ-030 res_wrap=1 when res_data < previous term of same run; first term of run res_wrap=0.
REQ-031 res_idx counts 0..cmd_count-1, wraps past 65535 never (cmd_count is 16-bit).
REQ-032 Any bit with both rails high in a synchronized sample in WAIT_DATA or WAIT_NULL: err=2, go to ERROR.
REQ-033 Cycles in ARM, WAIT_DATA or WAIT_NULL exceeding TIMEOUT: err=1, go to ERROR; PRESENT never times out.
REQ-034 ERROR: fib_rst=1, fib_start=0, fib_ack=0, res_valid=0, busy=1; exit only via rst_n; illegal code wins if both errors in same cycle.
REQ-035 cmd_valid outside IDLE SHALL be ignored.

Reset
REQ-036 On rst_n=0 asynchronously: state IDLE, fib_rst=1, fib_start=0, fib_ack=0, res_valid=0, res_data=0, res_idx=0, res_wrap=0, busy=0, err=0, synchronizers cleared.
REQ-037 In IDLE after reset fib_rst SHALL remain 1; it deasserts only in ARM.
REQ-038 Reset mid-run SHALL abandon the run with no further res_valid.

Verification
REQ-039 rst_n low then cmd_count=5, res_ready=1, behavioral ring model -> terms 1,1,2,3,5 with res_idx 0..4, busy drops after fifth NULL.
REQ-040 res_ready held 0 for 50 cycles on term 2 -> fib_ack stays 0, res_data stable, no lost term, sequence resumes 2,3.
REQ-041 WIDTH=8, cmd_count=14 -> term 13 is 377 mod 256 = 121 with res_wrap=1, all earlier res_wrap=0.
REQ-042 Ring model stalls DATA for TIMEOUT+1 cycles -> err=1, state ERROR, fib_rst=1.
REQ-043 Inject both rails high on bit 3 -> err=2 within 3 cycles of injection, res_valid never asserted for that word.
REQ-044 rst_n pulsed during PRESENT -> all outputs at reset values immediately, new command then yields term 1 at res_idx 0.
